// File: rtl/zigbee_pkg.sv
// Shared types and constants for the 802.15.4 symbol deframer.
package zigbee_pkg;

  // One recovered O-QPSK symbol.
  localparam int SYMBOL_W = 4;

  // Start-of-frame delimiter. The low nibble goes on air first.
  localparam logic [7:0] SFD_DEFAULT = 8'hA7;

  // Largest PSDU that the 7-bit PHR length field can describe.
  localparam int MAX_PSDU = 127;
  localparam int LEN_W    = $clog2(MAX_PSDU + 1);

  // States of the framing FSM.
  typedef enum logic [2:0] {
    ST_HUNT,
    ST_SFD_HI,
    ST_PHR_LO,
    ST_PHR_HI,
    ST_PAY_LO,
    ST_PAY_HI
  } state_e;

  // Builds a byte from two symbols. The low symbol is the first one received.
  function automatic logic [7:0] join_nibbles(input logic [SYMBOL_W-1:0] hi,
                                              input logic [SYMBOL_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/zigbee_nibble_reader.sv
// Drains the elastic FIFO read port at one symbol per two cycles at most.
// A read is issued, then the next cycle is spent consuming the returned data.
module zigbee_nibble_reader
  import zigbee_pkg::*;
#(
  parameter int DATA_WIDTH = SYMBOL_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_empty,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_rd_en,
  output logic                  o_nib_valid,
  output logic [DATA_WIDTH-1:0] o_nib
);

  logic pending_q;
  logic pending_d;

  // Never read an empty FIFO, and never read while a read is still in flight.
  // Reset also holds the request low, so every output is 0 while in reset.
  assign o_rd_en   = !i_empty && !pending_q && !i_rst;
  assign pending_d = o_rd_en;

  // The FIFO returns data one cycle after the read. Track that cycle here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) assignment. Every flop then samples pre-edge values.
      pending_q <= pending_d;
    end
  end

  assign o_nib_valid = pending_q;
  assign o_nib       = i_data;

endmodule

// File: rtl/zigbee_deframer.sv
// 802.15.4 deframer. It hunts for the preamble and SFD, reads the PHR length,
// and reassembles the payload symbols into a byte stream with sof/eof markers.
module zigbee_deframer
  import zigbee_pkg::*;
#(
  parameter int         DATA_WIDTH       = SYMBOL_W,
  parameter int         PREAMBLE_NIBBLES = 8,
  parameter logic [7:0] SFD_VALUE        = SFD_DEFAULT,
  parameter int         TIMEOUT_CYCLES   = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_empty,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_rd_en,
  output logic [7:0]            o_byte,
  output logic                  o_byte_valid,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic [LEN_W-1:0]      o_len,
  output logic                  o_len_valid,
  output logic                  o_sync_err,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam int                ZCNT_W   = $clog2(PREAMBLE_NIBBLES + 1);
  localparam logic [ZCNT_W-1:0] ZCNT_MAX = ZCNT_W'(PREAMBLE_NIBBLES);
  localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

  // Symbol stream coming from the FIFO handshake.
  logic [DATA_WIDTH-1:0] rd_nib;
  logic                  nib_valid;
  logic [SYMBOL_W-1:0]   nib;

  zigbee_nibble_reader #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_reader (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_empty    (i_empty),
    .i_data     (i_data),
    .o_rd_en    (o_rd_en),
    .o_nib_valid(nib_valid),
    .o_nib      (rd_nib)
  );

  assign nib = rd_nib[SYMBOL_W-1:0];

  // Framing state.
  state_e              state_q,  state_d;
  logic [ZCNT_W-1:0]   zcnt_q,   zcnt_d;
  logic [SYMBOL_W-1:0] lo_q,     lo_d;
  logic [LEN_W-1:0]    rem_q,    rem_d;
  logic [IDLE_W-1:0]   idle_q,   idle_d;

  // Registered outputs.
  logic [7:0]          byte_q,       byte_d;
  logic                byte_valid_q, byte_valid_d;
  logic                sof_q,        sof_d;
  logic                eof_q,        eof_d;
  logic [LEN_W-1:0]    len_q,        len_d;
  logic                len_valid_q,  len_valid_d;
  logic                sync_err_q,   sync_err_d;
  logic                frame_err_q,  frame_err_d;
  logic                busy_q,       busy_d;

  logic                timeout;
  logic [LEN_W-1:0]    phr_len;

  // PHR bit 7 is reserved. Only the low seven bits carry the length.
  assign phr_len = {nib[LEN_W-SYMBOL_W-1:0], lo_q};

  // A frame in progress is aborted after too many idle cycles without a symbol.
  assign timeout = (state_q != ST_HUNT) && (idle_q == IDLE_MAX);

  // Next-state logic for the framing FSM, the counters and the output strobes.
  always_comb begin
    // NOTE: every signal written here gets a default first. Some case paths do not assign it, and without a default a latch is inferred.
    state_d      = state_q;
    zcnt_d       = zcnt_q;
    lo_d         = lo_q;
    rem_d        = rem_q;
    byte_d       = byte_q;
    len_d        = len_q;
    busy_d       = busy_q;
    byte_valid_d = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    len_valid_d  = 1'b0;
    sync_err_d   = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q == ST_HUNT || nib_valid) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    if (timeout) begin
      // The abort takes priority. A symbol that lands in this cycle is dropped.
      state_d     = ST_HUNT;
      zcnt_d      = '0;
      idle_d      = '0;
      busy_d      = 1'b0;
      frame_err_d = 1'b1;
    end else if (nib_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (nib == '0) begin
            if (zcnt_q != ZCNT_MAX) zcnt_d = zcnt_q + 1'b1;
          end else if (nib == SFD_VALUE[SYMBOL_W-1:0] && zcnt_q == ZCNT_MAX) begin
            state_d = ST_SFD_HI;
          end else begin
            zcnt_d = '0;
          end
        end
        ST_SFD_HI: begin
          if (nib == SFD_VALUE[7:SYMBOL_W]) begin
            state_d = ST_PHR_LO;
            busy_d  = 1'b1;
          end else if (nib == '0) begin
            // A zero can start a new preamble, so it is counted.
            state_d = ST_HUNT;
            zcnt_d  = ZCNT_W'(1);
          end else begin
            state_d    = ST_HUNT;
            zcnt_d     = '0;
            sync_err_d = 1'b1;
          end
        end
        ST_PHR_LO: begin
          lo_d    = nib;
          state_d = ST_PHR_HI;
        end
        ST_PHR_HI: begin
          if (phr_len == '0) begin
            state_d     = ST_HUNT;
            zcnt_d      = '0;
            busy_d      = 1'b0;
            frame_err_d = 1'b1;
          end else begin
            state_d     = ST_PAY_LO;
            len_d       = phr_len;
            len_valid_d = 1'b1;
            rem_d       = phr_len;
          end
        end
        ST_PAY_LO: begin
          lo_d    = nib;
          state_d = ST_PAY_HI;
        end
        ST_PAY_HI: begin
          byte_d       = join_nibbles(nib, lo_q);
          byte_valid_d = 1'b1;
          sof_d        = (rem_q == len_q);
          eof_d        = (rem_q == LEN_W'(1));
          rem_d        = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_HUNT;
            zcnt_d  = '0;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_PAY_LO;
          end
        end
        default: begin
          state_d = ST_HUNT;
          zcnt_d  = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers. Reset drops any partial frame without a marker.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_HUNT;
      zcnt_q       <= '0;
      lo_q         <= '0;
      rem_q        <= '0;
      idle_q       <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      len_q        <= '0;
      len_valid_q  <= 1'b0;
      sync_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      zcnt_q       <= zcnt_d;
      lo_q         <= lo_d;
      rem_q        <= rem_d;
      idle_q       <= idle_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      len_q        <= len_d;
      len_valid_q  <= len_valid_d;
      sync_err_q   <= sync_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign o_byte       = byte_q;
  assign o_byte_valid = byte_valid_q;
  assign o_sof        = sof_q;
  assign o_eof        = eof_q;
  assign o_len        = len_q;
  assign o_len_valid  = len_valid_q;
  assign o_sync_err   = sync_err_q;
  assign o_frame_err  = frame_err_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_zigbee_deframer.sv
// Self-checking bench for zigbee_deframer. A queue-backed FIFO model feeds
// symbols. Expected bytes and lengths are built from a frame-level description.
module tb_zigbee_deframer;

  localparam int TIMEOUT = 1024;
  localparam int PRE     = 8;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [7:0] data;
  } byte_ev_t;

  logic       i_clk;
  logic       i_rst;
  logic       i_empty;
  logic [3:0] i_data;
  logic       o_rd_en;
  logic [7:0] o_byte;
  logic       o_byte_valid;
  logic       o_sof;
  logic       o_eof;
  logic [6:0] o_len;
  logic       o_len_valid;
  logic       o_sync_err;
  logic       o_frame_err;
  logic       o_busy;

  zigbee_deframer #(
    .DATA_WIDTH      (4),
    .PREAMBLE_NIBBLES(PRE),
    .SFD_VALUE       (8'hA7),
    .TIMEOUT_CYCLES  (TIMEOUT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_empty     (i_empty),
    .i_data      (i_data),
    .o_rd_en     (o_rd_en),
    .o_byte      (o_byte),
    .o_byte_valid(o_byte_valid),
    .o_sof       (o_sof),
    .o_eof       (o_eof),
    .o_len       (o_len),
    .o_len_valid (o_len_valid),
    .o_sync_err  (o_sync_err),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // FIFO contents, expected byte stream and expected lengths.
  logic [3:0] fifo_q[$];
  byte_ev_t   exp_q[$];
  logic [6:0] len_exp[$];
  logic [7:0] pay_q[$];
  bit         jitter = 0;

  // Monitor counters.
  int byte_cnt, eof_cnt, lenv_cnt, sync_cnt, ferr_cnt, rd_while_empty;
  int last_byte_cyc, ferr_cyc;

  initial i_clk = 1'b0;
  always #10 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // FIFO model. A read seen at the edge returns data one cycle later.
  initial begin
    logic rd_s;
    i_empty = 1'b1;
    i_data  = 4'h0;
    forever begin
      @(negedge i_clk);
      rd_s = o_rd_en;
      if (o_rd_en && i_empty) rd_while_empty++;
      @(posedge i_clk);
      #1;
      if (rd_s && !i_rst && fifo_q.size() > 0) i_data = fifo_q.pop_front();
      i_empty = (fifo_q.size() == 0) || (jitter && ($urandom_range(0, 3) == 0));
    end
  end

  // Output monitor and scoreboard. Outputs are sampled mid-cycle.
  initial begin
    byte_ev_t ev;
    logic     post_eof;
    post_eof = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        post_eof = 1'b0;
      end else begin
        if (post_eof) begin
          checks++;
          if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_eof: o_busy=%b want 0", o_busy);
          end
        end
        post_eof = 1'b0;
        if (o_byte_valid) begin
          byte_cnt++;
          last_byte_cyc = cyc;
          if (o_eof) begin
            eof_cnt++;
            post_eof = 1'b1;
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL byte_unexpected: got %h sof=%b eof=%b, want no byte", o_byte, o_sof, o_eof);
          end else begin
            ev = exp_q.pop_front();
            if ({o_sof, o_eof, o_byte} !== ev) begin
              errors++;
              $display("FAIL byte_stream: got %h sof=%b eof=%b, want %h sof=%b eof=%b",
                       o_byte, o_sof, o_eof, ev.data, ev.sof, ev.eof);
            end
          end
          if (!o_eof) begin
            checks++;
            if (o_busy !== 1'b1) begin
              errors++;
              $display("FAIL busy_in_frame: o_busy=%b want 1", o_busy);
            end
          end
        end
        if (o_len_valid) begin
          lenv_cnt++;
          checks++;
          if (len_exp.size() == 0) begin
            errors++;
            $display("FAIL len_unexpected: got %0d, want no length strobe", o_len);
          end else if (o_len !== len_exp[0]) begin
            errors++;
            $display("FAIL len_value: got %0d want %0d", o_len, len_exp[0]);
            void'(len_exp.pop_front());
          end else begin
            void'(len_exp.pop_front());
          end
        end
        if (o_sync_err) sync_cnt++;
        if (o_frame_err) begin
          ferr_cnt++;
          ferr_cyc = cyc;
        end
      end
    end
  end

  function automatic logic [22:0] out_vec();
    return {o_rd_en, o_byte, o_byte_valid, o_sof, o_eof, o_len,
            o_len_valid, o_sync_err, o_frame_err, o_busy};
  endfunction

  task automatic clear_mon();
    byte_cnt = 0; eof_cnt = 0; lenv_cnt = 0; sync_cnt = 0; ferr_cnt = 0;
  endtask

  task automatic fill_random(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Queues a frame (preamble, SFD, PHR, first nsend payload bytes) and records
  // the bytes and length that the frame description implies.
  task automatic send_frame(input logic [7:0] phr, input int nsend);
    logic [6:0] len;
    byte_ev_t   ev;
    len = phr[6:0];
    repeat (PRE) fifo_q.push_back(4'h0);
    fifo_q.push_back(4'h7);
    fifo_q.push_back(4'hA);
    fifo_q.push_back(phr[3:0]);
    fifo_q.push_back(phr[7:4]);
    if (len != 0) len_exp.push_back(len);
    for (int i = 0; i < nsend; i++) begin
      fifo_q.push_back(pay_q[i][3:0]);
      fifo_q.push_back(pay_q[i][7:4]);
      ev.sof  = (i == 0);
      ev.eof  = (i == int'(len) - 1);
      ev.data = pay_q[i];
      exp_q.push_back(ev);
    end
  endtask

  // Waits until the FIFO is drained and the deframer is idle, within a cycle budget.
  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || o_busy) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    repeat (8) @(negedge i_clk);
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain: still busy after %0d cycles, want idle", name, n);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++;
    if (out_vec() !== 23'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", out_vec());
    end
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if (out_vec() !== 23'h0) begin
      errors++;
      $display("FAIL post_reset_idle: got %h want 0", out_vec());
    end
  endtask

  task automatic test_nominal();
    clear_mon();
    pay_q = '{8'h12, 8'h34, 8'h56};
    send_frame(8'h03, 3);
    wait_quiet("nominal", 400);
    checks++;
    if (exp_q.size() != 0 || byte_cnt != 3) begin
      errors++;
      $display("FAIL nominal_bytes: got %0d bytes, %0d missing, want 3 bytes", byte_cnt, exp_q.size());
    end
    checks++;
    if (o_len !== 7'd3 || lenv_cnt != 1) begin
      errors++;
      $display("FAIL nominal_len: got len=%0d strobes=%0d want 3 and 1", o_len, lenv_cnt);
    end
    checks++;
    if (sync_cnt != 0 || ferr_cnt != 0 || eof_cnt != 1) begin
      errors++;
      $display("FAIL nominal_flags: got sync=%0d ferr=%0d eof=%0d want 0 0 1", sync_cnt, ferr_cnt, eof_cnt);
    end
  endtask

  task automatic test_short_preamble();
    logic [3:0] pat[9];
    clear_mon();
    pat = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'hA, 4'h3, 4'h0};
    for (int i = 0; i < 9; i++) fifo_q.push_back(pat[i]);
    wait_quiet("short", 200);
    checks++;
    if (lenv_cnt != 0 || byte_cnt != 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL short_preamble: got lenv=%0d bytes=%0d busy=%b want 0 0 0", lenv_cnt, byte_cnt, o_busy);
    end
  endtask

  task automatic test_bad_sfd();
    clear_mon();
    repeat (PRE) fifo_q.push_back(4'h0);
    fifo_q.push_back(4'h7);
    fifo_q.push_back(4'hB);
    wait_quiet("bad_sfd", 200);
    checks++;
    if (sync_cnt != 1 || ferr_cnt != 0 || lenv_cnt != 0) begin
      errors++;
      $display("FAIL bad_sfd_err: got sync=%0d ferr=%0d lenv=%0d want 1 0 0", sync_cnt, ferr_cnt, lenv_cnt);
    end
    fill_random(4);
    send_frame(8'h04, 4);
    wait_quiet("after_bad_sfd", 400);
    checks++;
    if (exp_q.size() != 0 || byte_cnt != 4 || sync_cnt != 1) begin
      errors++;
      $display("FAIL after_bad_sfd: got bytes=%0d sync=%0d want 4 1", byte_cnt, sync_cnt);
    end
  endtask

  task automatic test_zero_len();
    clear_mon();
    send_frame(8'h00, 0);
    wait_quiet("zero_len", 200);
    checks++;
    if (ferr_cnt != 1 || byte_cnt != 0 || lenv_cnt != 0) begin
      errors++;
      $display("FAIL zero_len: got ferr=%0d bytes=%0d lenv=%0d want 1 0 0", ferr_cnt, byte_cnt, lenv_cnt);
    end
    fill_random(5);
    send_frame(8'h85, 5);
    wait_quiet("reserved_bit", 400);
    checks++;
    if (o_len !== 7'd5 || exp_q.size() != 0 || byte_cnt != 5 || ferr_cnt != 1) begin
      errors++;
      $display("FAIL reserved_bit_len: got len=%0d bytes=%0d ferr=%0d want 5 5 1", o_len, byte_cnt, ferr_cnt);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_mon();
    fill_random(4);
    send_frame(8'h04, 2);
    while (ferr_cnt == 0 && n < TIMEOUT + 400) begin
      @(negedge i_clk);
      n++;
    end
    repeat (5) @(negedge i_clk);
    checks++;
    if (ferr_cnt != 1) begin
      errors++;
      $display("FAIL timeout_err: got ferr=%0d want 1", ferr_cnt);
    end
    checks++;
    if (ferr_cyc - last_byte_cyc != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles want %0d", ferr_cyc - last_byte_cyc, TIMEOUT);
    end
    checks++;
    if (eof_cnt != 0 || byte_cnt != 2 || o_busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_abort: got eof=%0d bytes=%0d busy=%b want 0 2 0", eof_cnt, byte_cnt, o_busy);
    end
    fill_random(3);
    send_frame(8'h03, 3);
    wait_quiet("after_timeout", 400);
    checks++;
    if (exp_q.size() != 0 || byte_cnt != 5) begin
      errors++;
      $display("FAIL after_timeout: got bytes=%0d want 5", byte_cnt);
    end
  endtask

  task automatic test_random();
    int total = 0;
    int n;
    clear_mon();
    jitter = 1;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 12);
      total += n;
      fill_random(n);
      send_frame(8'(n), n);
    end
    wait_quiet("random", 4000);
    jitter = 0;
    checks++;
    if (exp_q.size() != 0 || byte_cnt != total || lenv_cnt != 6) begin
      errors++;
      $display("FAIL random_frames: got bytes=%0d lenv=%0d want %0d 6", byte_cnt, lenv_cnt, total);
    end
    checks++;
    if (sync_cnt != 0 || ferr_cnt != 0 || eof_cnt != 6) begin
      errors++;
      $display("FAIL random_flags: got sync=%0d ferr=%0d eof=%0d want 0 0 6", sync_cnt, ferr_cnt, eof_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_mon();
    fill_random(6);
    send_frame(8'h06, 6);
    while (byte_cnt < 2 && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if (out_vec() !== 23'h0) begin
      errors++;
      $display("FAIL reset_async: got %h want 0", out_vec());
    end
    repeat (3) @(negedge i_clk);
    fifo_q.delete();
    exp_q.delete();
    len_exp.delete();
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);
    checks++;
    if (byte_cnt != 2 || eof_cnt != 0 || ferr_cnt != 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: got bytes=%0d eof=%0d ferr=%0d busy=%b want 2 0 0 0",
               byte_cnt, eof_cnt, ferr_cnt, o_busy);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    for (int f = 0; f < 3; f++) begin
      fill_random(1);
      send_frame(8'h01, 1);
    end
    wait_quiet("back_to_back", 600);
    checks++;
    if (exp_q.size() != 0 || byte_cnt != 3 || eof_cnt != 3) begin
      errors++;
      $display("FAIL back_to_back: got bytes=%0d eof=%0d want 3 3", byte_cnt, eof_cnt);
    end
    checks++;
    if (rd_while_empty != 0) begin
      errors++;
      $display("FAIL rd_while_empty: got %0d reads want 0", rd_while_empty);
    end
  endtask

  initial begin
    i_rst = 1'b1;
    test_reset();
    test_nominal();
    test_short_preamble();
    test_bad_sfd();
    test_zero_len();
    test_timeout();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zigbee_deframer.md
Name: zigbee_deframer

Overview:
- Sits directly downstream of the CDR + elastic FIFO wrapper and drains its 4-bit read port.
- Each 4-bit value is one recovered O-QPSK symbol, sent LSB nibble first.
- Hunts for the 802.15.4 preamble and SFD, extracts the PHR frame length, and reassembles payload nibbles into bytes.
- Produces a byte stream with start/end-of-frame markers for the MAC/CPU side.

Parameters:
- DATA_WIDTH, 4, FIFO data width (one symbol).
- PREAMBLE_NIBBLES, 8, minimum consecutive 0x0 symbols required before the SFD is accepted.
- SFD_VALUE, 8'hA7, start-of-frame delimiter.
- TIMEOUT_CYCLES, 1024, idle clock cycles mid-frame before the frame is aborted.

Ports:
- i_clk  in  1  system clock (50 MHz).
- i_rst  in  1  asynchronous, active-high reset.
- i_empty  in  1  FIFO empty flag (outEmpty).
- i_data  in  DATA_WIDTH  FIFO read data (outData); valid the cycle after o_rd_en.
- o_rd_en  out  1  FIFO read enable (drives inReadEnable).
- o_byte  out  8  assembled payload byte.
- o_byte_valid  out  1  one-cycle strobe, o_byte valid.
- o_sof  out  1  qualifies the first payload byte.
- o_eof  out  1  qualifies the last payload byte.
- o_len  out  7  PHR frame length; held until the next PHR.
- o_len_valid  out  1  one-cycle strobe when a non-zero PHR is accepted.
- o_sync_err  out  1  one-cycle strobe on SFD mismatch.
- o_frame_err  out  1  one-cycle strobe on zero length or timeout abort.
- o_busy  out  1  high from SFD acceptance to the last byte or abort.

Behaviour:
- Reset: all outputs 0, state HUNT, counters 0. Asynchronous reset mid-frame discards the partial frame; no eof or error is emitted.
- Read handshake:
  - o_rd_en = !i_empty && !pending.
  - pending is set the cycle after o_rd_en and cleared the following cycle.
  - A nibble is consumed when pending=1, so at most one read per 2 cycles.
  - o_rd_en is never asserted while i_empty=1.
- HUNT:
  - nibble 0x0: zcnt++, saturating at PREAMBLE_NIBBLES.
  - nibble == SFD_VALUE[3:0] (0x7) with zcnt ≥ PREAMBLE_NIBBLES: go to SFD_HI.
  - any other nibble: zcnt = 0.
- SFD_HI:
  - nibble == SFD_VALUE[7:4] (0xA): go to PHR_LO, set o_busy.
  - nibble 0x0: go to HUNT with zcnt = 1, no error.
  - any other nibble: o_sync_err pulse, go to HUNT with zcnt = 0.
- PHR_LO: latch the low nibble, go to PHR_HI.
- PHR_HI:
  - Length = {hi,lo}[6:0]; bit 7 is reserved and ignored.
  - len == 0: o_frame_err pulse, o_busy cleared, go to HUNT.
  - len != 0: o_len updated, o_len_valid pulses for one cycle, remaining = len, go to PAY_LO.
- PAY_LO: latch the low nibble, go to PAY_HI.
- PAY_HI:
  - o_byte = {hi,lo}, o_byte_valid pulses; outputs are registered, 1 cycle after the hi nibble is consumed.
  - o_sof is set on the first byte; o_eof is set when remaining == 1. Both are set when len == 1.
  - remaining--. If remaining reaches 0: go to HUNT, clear o_busy and zcnt. Otherwise go to PAY_LO.
- Timeout:
  - In any state other than HUNT, idle counts cycles with no nibble consumed; it resets on each nibble.
  - idle == TIMEOUT_CYCLES-1: o_frame_err pulse, go to HUNT, zcnt = 0, o_busy cleared, no o_eof.
- Back-to-back frames: the next preamble is hunted immediately after eof; no dead cycles are required beyond the read handshake.
- Error precedence: a nibble arriving in the same cycle as the timeout expiry is ignored; the abort wins.

Decomposition:
- zigbee_pkg holds:
  - the state enum (HUNT, SFD_HI, PHR_LO, PHR_HI, PAY_LO, PAY_HI);
  - SYMBOL_W = 4;
  - SFD_DEFAULT = 8'hA7;
  - MAX_PSDU = 127.
- One natural sub-module, zigbee_nibble_reader. It owns the o_rd_en/pending handshake and presents nibble + nibble_valid to the framing FSM.

Test Plan:
- Nominal frame: 8×0x0, 7, A, PHR 3,0, payload nibbles 2,1,4,3,6,5 → o_len=3 with o_len_valid pulse; bytes 0x12 (sof), 0x34, 0x56 (eof); o_busy falls after 0x56.
- Short preamble: 5×0x0, 7, A, 3, 0 → no o_len_valid, no bytes, state stays HUNT.
- Bad SFD: 8×0x0, 7, B → one o_sync_err pulse. A following nominal frame decodes correctly.
- Zero length: valid sync, then PHR 0,0 → o_frame_err pulse, no o_byte_valid. PHR 5,8 (0x85) in a later frame → o_len=5.
- Stall/timeout: len=4; stop the FIFO (i_empty=1) after 2 bytes → o_frame_err exactly TIMEOUT_CYCLES cycles after the last nibble; no o_eof; next frame decodes.
- Reset: assert i_rst mid-payload → all outputs 0 immediately (asynchronous), no eof. Back-to-back frames with len=1 → byte carries sof and eof together; o_rd_en never high while empty.
